// File: rtl/seq_detect_param.sv
// Serial pattern detector with a loadable pattern, optional overlapping matches,
// a registered Moore match pulse, a sticky "seen" flag and a saturating match counter.
module seq_detect_param #(
    parameter int              PAT_W    = 4,
    parameter logic [PAT_W-1:0] PAT_INIT = 4'b1101,
    parameter int              OVERLAP  = 1,
    parameter int              CNT_W    = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             w,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             out,
    output logic             seen,
    output logic [CNT_W-1:0] count
);

    localparam int               FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  pat_reg;
    logic [PAT_W-1:0]  hist_reg;
    logic [FILL_W-1:0] fill_reg;
    logic              out_reg;
    logic              seen_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              accept;
    logic [PAT_W-1:0]  hist_next;
    logic [FILL_W-1:0] fill_next;
    logic [PAT_W-1:0]  eq_bits;
    logic              match;

    // A bit arriving together with a pattern load is dropped.
    assign accept    = en && !pat_load;
    assign hist_next = {hist_reg[PAT_W-2:0], w};
    assign fill_next = (fill_reg == FILL_MAX) ? FILL_MAX : fill_reg + FILL_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < PAT_W; gi++) begin : g_eq
            assign eq_bits[gi] = hist_next[gi] ~^ pat_reg[gi];
        end
    endgenerate

    // Match is judged on the post-shift history and fill of this edge.
    assign match = accept && (fill_next == FILL_MAX) && (&eq_bits);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pat_reg   <= PAT_INIT;
            hist_reg  <= '0;
            fill_reg  <= '0;
            out_reg   <= 1'b0;
            seen_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            if (pat_load) begin
                pat_reg  <= pat_in;
                fill_reg <= '0;
                out_reg  <= 1'b0;
            end else if (en) begin
                hist_reg <= hist_next;
                fill_reg <= (match && (OVERLAP == 0)) ? '0 : fill_next;
                out_reg  <= match;
            end else begin
                out_reg  <= 1'b0;
            end

            // A match wins over a coincident clear: the match is counted fresh.
            if (match) begin
                seen_reg <= 1'b1;
                if (cnt_clr)
                    count_reg <= CNT_W'(1);
                else if (count_reg != CNT_MAX)
                    count_reg <= count_reg + CNT_W'(1);
            end else if (cnt_clr) begin
                seen_reg  <= 1'b0;
                count_reg <= '0;
            end
        end
    end

    assign out   = out_reg;
    assign seen  = seen_reg;
    assign count = count_reg;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: three detector instances (overlap, non-overlap, 2-bit counter)
// share one stimulus stream; each step checks outputs against hand-computed values.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       resetn;
    logic       en;
    logic       w;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       cnt_clr;

    logic       out_a, seen_a;
    logic [7:0] count_a;
    logic       out_b, seen_b;
    logic [7:0] count_b;
    logic       out_c, seen_c;
    logic [1:0] count_c;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(4), .PAT_INIT(4'b1101), .OVERLAP(1), .CNT_W(8)) dut_a (
        .clk(clk), .resetn(resetn), .en(en), .w(w), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .out(out_a), .seen(seen_a), .count(count_a)
    );

    seq_detect_param #(.PAT_W(4), .PAT_INIT(4'b1101), .OVERLAP(0), .CNT_W(8)) dut_b (
        .clk(clk), .resetn(resetn), .en(en), .w(w), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .out(out_b), .seen(seen_b), .count(count_b)
    );

    seq_detect_param #(.PAT_W(4), .PAT_INIT(4'b1101), .OVERLAP(1), .CNT_W(2)) dut_c (
        .clk(clk), .resetn(resetn), .en(en), .w(w), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .out(out_c), .seen(seen_c), .count(count_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of en/w and settle just after the edge.
    task automatic step(input logic e, input logic b);
        en = e;
        w  = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0]  seq7, ea7, eb7;
        logic [15:0] seq16, ea16, eb16;

        resetn = 1'b0; en = 1'b0; w = 1'b0; pat_load = 1'b0; pat_in = 4'b0000; cnt_clr = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("rst_out_a",   32'(out_a),   0);
        chk("rst_seen_a",  32'(seen_a),  0);
        chk("rst_count_a", 32'(count_a), 0);
        chk("rst_out_b",   32'(out_b),   0);
        chk("rst_count_c", 32'(count_c), 0);
        resetn = 1'b1;

        // 1101101: overlap matches after bits 4 and 7; non-overlap only after bit 4
        seq7 = 7'b1101101; ea7 = 7'b0001001; eb7 = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, seq7[i]);
            $display("bit %0d w=%0b out_a=%0b out_b=%0b", 7 - i, seq7[i], out_a, out_b);
            chk($sformatf("ovl_out_a_bit%0d", 7 - i), 32'(out_a), 32'(ea7[i]));
            chk($sformatf("novl_out_b_bit%0d", 7 - i), 32'(out_b), 32'(eb7[i]));
        end
        chk("ovl_count_a",  32'(count_a), 2);
        chk("novl_count_b", 32'(count_b), 1);
        chk("ovl_count_c",  32'(count_c), 2);
        chk("seen_a",       32'(seen_a),  1);
        step(1'b0, 1'b0);
        chk("idle_out_a_falls", 32'(out_a), 0);

        // 1,1,0, three idle cycles, then 1 -> single pulse
        resetn = 1'b0; step(1'b0, 1'b0); resetn = 1'b1;
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            chk($sformatf("gap_out_a_%0d", i), 32'(out_a), 0);
        end
        step(1'b1, 1'b1);
        $display("gap resume: out_a=%0b count_a=%0d", out_a, count_a);
        chk("gap_match_out_a", 32'(out_a), 1);
        step(1'b0, 1'b0);
        chk("gap_after_out_a", 32'(out_a), 0);
        chk("gap_count_a",     32'(count_a), 1);

        // 1,1,0, reset, then 1 -> history discarded; 4 fresh bits required
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0);
        resetn = 1'b0; step(1'b1, 1'b1); resetn = 1'b1;
        chk("midrst_out_a",   32'(out_a),   0);
        chk("midrst_seen_a",  32'(seen_a),  0);
        chk("midrst_count_a", 32'(count_a), 0);
        step(1'b1, 1'b1);
        chk("midrst_b1_out_a", 32'(out_a), 0);
        chk("midrst_b1_count_a", 32'(count_a), 0);
        step(1'b1, 1'b1); chk("midrst_b2_out_a", 32'(out_a), 0);
        step(1'b1, 1'b0); chk("midrst_b3_out_a", 32'(out_a), 0);
        step(1'b1, 1'b1); chk("midrst_b4_out_a", 32'(out_a), 1);

        // Load 0110 alongside a valid bit; that bit is dropped
        pat_load = 1'b1; pat_in = 4'b0110;
        step(1'b1, 1'b0);
        pat_load = 1'b0; pat_in = 4'b0000;
        chk("load_out_a", 32'(out_a), 0);
        step(1'b1, 1'b0); chk("load_b1_out_a", 32'(out_a), 0);
        step(1'b1, 1'b1); chk("load_b2_out_a", 32'(out_a), 0);
        step(1'b1, 1'b1); chk("load_b3_out_a", 32'(out_a), 0);
        step(1'b1, 1'b0); chk("load_b4_out_a", 32'(out_a), 1);
        chk("load_count_a", 32'(count_a), 2);

        // Reset overrides pat_load/cnt_clr/en: pattern returns to 1101
        resetn = 1'b0; pat_load = 1'b1; pat_in = 4'b0000; cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        resetn = 1'b1; pat_load = 1'b0; cnt_clr = 1'b0;
        chk("rstovr_count_a", 32'(count_a), 0);

        // Five overlapping matches: 2-bit counter saturates at 3
        seq16 = 16'b1101101101101101;
        ea16  = 16'b0001001001001001;
        eb16  = 16'b0001000001000001;
        for (int i = 15; i >= 0; i--) begin
            step(1'b1, seq16[i]);
            chk($sformatf("sat_out_a_bit%0d", 16 - i), 32'(out_a), 32'(ea16[i]));
            chk($sformatf("sat_out_b_bit%0d", 16 - i), 32'(out_b), 32'(eb16[i]));
            if (i == 6) chk("sat_count_c_bit10", 32'(count_c), 3);
        end
        $display("after 16 bits: count_a=%0d count_b=%0d count_c=%0d", count_a, count_b, count_c);
        chk("sat_count_c", 32'(count_c), 3);
        chk("sat_count_a", 32'(count_a), 5);
        chk("sat_count_b", 32'(count_b), 3);
        chk("sat_seen_c",  32'(seen_c),  1);

        // Sixth match coincides with cnt_clr: match wins
        step(1'b1, 1'b1); step(1'b1, 1'b0);
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        cnt_clr = 1'b0;
        $display("clr+match: out_c=%0b seen_c=%0b count_c=%0d", out_c, seen_c, count_c);
        chk("clrm_out_c",   32'(out_c),   1);
        chk("clrm_count_c", 32'(count_c), 1);
        chk("clrm_seen_c",  32'(seen_c),  1);
        chk("clrm_count_a", 32'(count_a), 1);
        chk("clrm_count_b", 32'(count_b), 0);
        chk("clrm_seen_b",  32'(seen_b),  0);

        // Plain clear with no match
        cnt_clr = 1'b1;
        step(1'b0, 1'b0);
        cnt_clr = 1'b0;
        chk("clr_count_c", 32'(count_c), 0);
        chk("clr_seen_c",  32'(seen_c),  0);
        chk("clr_out_c",   32'(out_c),   0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
